// File: rtl/wb_burst_capture.sv
// wb_burst_capture: Wishbone B3 write-burst capture slave replaying beats on a valid/ready stream
module wb_burst_capture #(
    parameter int WB_AW      = 32,
    parameter int WB_DW      = 32,
    parameter int DEPTH      = 16,
    parameter int CHECK_ADDR = 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [WB_AW-1:0]         wb_adr_i,
    input  logic [WB_DW-1:0]         wb_dat_i,
    input  logic [WB_DW/8-1:0]       wb_sel_i,
    input  logic                     wb_we_i,
    input  logic [1:0]               wb_bte_i,
    input  logic [2:0]               wb_cti_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic [WB_DW-1:0]         wb_dat_o,
    output logic                     cap_valid_o,
    input  logic                     cap_ready_i,
    output logic [WB_AW-1:0]         cap_adr_o,
    output logic [WB_DW-1:0]         cap_dat_o,
    output logic [WB_DW/8-1:0]       cap_sel_o,
    output logic                     cap_last_o,
    output logic [$clog2(DEPTH):0]   cap_level_o,
    output logic [7:0]               err_cnt_o
);
    localparam int SW = WB_DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = 1 + SW + WB_DW + WB_AW;

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, state_n;
    logic             term_q;
    logic [1:0]       bte_q;
    logic [1:0]       bte_use;
    logic [WB_AW-1:0] exp_adr;
    logic             req, full, blocked, svc, cti_ok, adr_ok, store, bad, pop;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head;

    // Next expected beat address: linear increment, or wrap inside a k*step aligned block.
    function automatic logic [WB_AW-1:0] next_adr(input logic [WB_AW-1:0] a, input logic [1:0] b);
        logic [WB_AW-1:0] inc, m;
        inc = a + WB_AW'(SW);
        m = (b == 2'b01) ? WB_AW'(4 * SW - 1) : (b == 2'b10) ? WB_AW'(8 * SW - 1) : WB_AW'(16 * SW - 1);
        return (b == 2'b00) ? inc : ((a & ~m) | (inc & m));
    endfunction

    assign req     = wb_cyc_i & wb_stb_i;
    assign full    = level == LW'(DEPTH);
    assign blocked = ((wb_ack_o | wb_err_o) & term_q) | full;
    assign svc     = req & ~blocked;
    assign cti_ok  = (wb_cti_i == 3'b000) || (wb_cti_i == 3'b010) || (wb_cti_i == 3'b111);
    assign adr_ok  = (CHECK_ADDR == 0) || (state == IDLE) || (wb_adr_i == exp_adr);
    assign bte_use = (state == IDLE) ? wb_bte_i : bte_q;
    assign pop     = cap_valid_o & cap_ready_i;
    assign wb_dat_o = '0;

    // Decide store/err for the current request and the next protocol state.
    always_comb begin
        store   = svc & wb_we_i & cti_ok & adr_ok;
        bad     = svc & ~store;
        state_n = state;
        if (state == BURST && !wb_cyc_i)
            state_n = IDLE;
        else if (bad)
            state_n = IDLE;
        else if (store)
            state_n = (wb_cti_i == 3'b010) ? BURST : IDLE;
    end

    // Protocol state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Registered responses; term_q remembers whether the answered beat closed its cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            term_q    <= 1'b0;
            err_cnt_o <= 8'd0;
        end else begin
            wb_ack_o  <= store;
            wb_err_o  <= bad;
            term_q    <= wb_cti_i != 3'b010;
            err_cnt_o <= (bad && err_cnt_o != 8'hFF) ? err_cnt_o + 8'd1 : err_cnt_o;
        end
    end

    // Burst tracking: latch bte on the opening beat and predict the next address.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bte_q   <= 2'b00;
            exp_adr <= '0;
        end else if (store) begin
            bte_q   <= bte_use;
            exp_adr <= next_adr(wb_adr_i, bte_use);
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the level unchanged.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= store ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
            level  <= level + LW'(store) - LW'(pop);
        end
    end

    // Beat storage; last marks a beat that closed its cycle.
    always_ff @(posedge wb_clk_i) begin
        if (store)
            mem[wr_ptr] <= {wb_cti_i != 3'b010, wb_sel_i, wb_dat_i, wb_adr_i};
    end

    assign head        = mem[rd_ptr];
    assign cap_valid_o = level != '0;
    assign cap_level_o = level;
    assign cap_adr_o   = cap_valid_o ? head[WB_AW-1:0] : '0;
    assign cap_dat_o   = cap_valid_o ? head[WB_AW +: WB_DW] : '0;
    assign cap_sel_o   = cap_valid_o ? head[WB_AW+WB_DW +: SW] : '0;
    assign cap_last_o  = cap_valid_o & head[EW-1];
endmodule

// File: doc/wb_burst_capture.md
Name: wb_burst_capture

Overview:
Parametrised Wishbone B3 slave. It captures write beats (classic, incrementing and wrapping bursts) into an internal FIFO and replays each beat on a valid/ready stream with a last-of-burst flag. It is used in benches and on-chip debug paths as a synthesizable capture endpoint behind Wishbone streaming masters. Back-pressure is applied by withholding ack, and protocol violations are answered with err.

Parameters:
WB_AW, 32, address width (byte address)
WB_DW, 32, data width; multiple of 8
DEPTH, 16, FIFO depth in beats; power of 2, >=2
CHECK_ADDR, 1, 1 = check that each burst beat address matches the expected next address

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset; asynchronous, active-high
wb_adr_i  in  WB_AW  address
wb_dat_i  in  WB_DW  write data
wb_sel_i  in  WB_DW/8  byte select
wb_we_i  in  1  write enable
wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_ack_o  out  1  registered ack
wb_err_o  out  1  registered err
wb_dat_o  out  WB_DW  read data; always 0
cap_valid_o  out  1  stream beat valid
cap_ready_i  in  1  stream beat ready
cap_adr_o  out  WB_AW  captured address
cap_dat_o  out  WB_DW  captured data
cap_sel_o  out  WB_DW/8  captured byte select
cap_last_o  out  1  beat ended a cycle (cti 111, or a classic cycle)
cap_level_o  out  $clog2(DEPTH)+1  FIFO occupancy
err_cnt_o  out  8  saturating count of err responses

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, state IDLE, err_cnt 0.
- Requests:
  - Request = cyc & stb.
  - A request at cycle N is serviced when not blocked, and ack or err is driven at N+1 for one beat.
  - Blocked when: (a) ack_o|err_o is high and the beat just answered was classic or cti 111 (prevents a double response), or (b) FIFO not full is false.
- Space: FIFO not full uses the registered level; a pop in the same cycle does not free space until N+1.
- Read request (we=0): err_o at N+1; nothing stored.
- Unsupported cti (001, 011-110): err_o; nothing stored.
- Beat-by-beat bursts: incrementing bursts may be acked every cycle while the master holds stb and the FIFO has space.
- States:
  - IDLE: first write beat is stored and acked. cti 010 -> BURST and latches bte; classic/111 -> stay.
  - BURST: each beat is stored and acked. cti 111 -> IDLE. cyc deasserted -> IDLE; the last stored beat keeps cap_last_o=0.
- Expected next address:
  - step = WB_DW/8.
  - Linear: addr+step.
  - Wrap-k (k=4/8/16): low log2(k*step) bits = (low+step) mod k*step; upper bits held.
- Address check (CHECK_ADDR=1, in BURST):
  - Mismatch -> err_o, beat not stored, state -> IDLE. Later beats of that cycle are treated as new IDLE beats.
  - CHECK_ADDR=0: address is stored as presented.
- bte change mid-burst: ignored; the latched bte is used.
- FIFO:
  - Push on each acked beat; pop when cap_valid_o & cap_ready_i.
  - cap_* are driven from the FIFO head; cap_valid_o = level != 0.
  - Push and pop in the same cycle: level unchanged; an empty FIFO stays first-word latency 1 (push at N is visible at N+1).
- err_cnt_o: +1 per err_o pulse; saturates at 255.
- Pointers wrap modulo DEPTH; level ranges 0..DEPTH.

Test Plan:
- Classic write adr 0x100, dat 0xDEADBEEF, sel F -> ack one cycle; cap beat {0x100, 0xDEADBEEF, F, last=1}; ack never two cycles in a row.
- Incrementing linear burst of 4 from 0x40, cti 010,010,010,111 -> acks on 4 consecutive cycles; stream beats at 0x40, 0x44, 0x48, 0x4C; last only on 0x4C.
- Wrap4 burst from 0x38 -> addresses 0x38, 0x3C, 0x30, 0x34 accepted; presenting 0x40 as the third beat -> err_o, err_cnt 1, only 2 beats stored.
- DEPTH=4, cap_ready_i=0, 6-beat burst -> 4 acks, then ack held low with stb high; raise ready -> remaining 2 acked, 6 beats in order, level peaks at 4.
- Read request, and cti=001 write -> err_o each, no beats stored, err_cnt 2, wb_dat_o 0.
- Assert wb_rst_i mid-burst with 3 beats queued -> ack/err/valid 0 immediately, level 0; next classic write is captured normally.
